// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the PISO serializer: FSM state encoding and
// the helper that sizes the bit counter.
package piso_serializer_pkg;

  // IDLE: line quiet, sout held 0. SHIFT: a word is on the line.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Ceiling log2, never less than 1, so a 2-bit word still gets a
  // one-bit counter. Valid for values up to 2**30.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter. Takes a WIDTH-bit word through
// a valid/ready handshake and drives it out one bit per clock on sout.
// A new word can be accepted on the edge that retires the last bit,
// so consecutive words go out with no idle gap.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int              CW          = clog2(WIDTH);
  localparam logic [CW-1:0]   LP_LAST_IDX = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic             r_sout;
  logic             r_sout_valid;
  logic             r_frame_start;

  logic             w_last_bit;
  logic             w_accept;
  logic [WIDTH-1:0] w_shift_next;
  logic             w_first_bit;
  logic             w_next_bit;

  // r_cnt counts bits still to come after the one on the line, so
  // r_cnt == 0 in SHIFT means the last bit is being driven now.
  assign w_last_bit   = (r_state == ST_SHIFT) && (r_cnt == '0);
  assign load_ready   = (r_state == ST_IDLE) || w_last_bit;
  assign w_accept     = load_valid && load_ready;

  // The register keeps the bit currently on the line at its output
  // end; shifting exposes the next one.
  assign w_shift_next = LSB_FIRST ? (r_shift >> 1) : (r_shift << 1);
  assign w_first_bit  = LSB_FIRST ? load_data[0] : load_data[WIDTH-1];
  assign w_next_bit   = LSB_FIRST ? w_shift_next[0] : w_shift_next[WIDTH-1];

  // FSM with registered serial outputs; accept takes priority so a
  // last-bit edge with a waiting word starts the next frame directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_shift       <= '0;
      r_cnt         <= '0;
      r_sout        <= 1'b0;
      r_sout_valid  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (w_accept) begin
      r_state       <= ST_SHIFT;
      r_shift       <= load_data;
      r_cnt         <= LP_LAST_IDX;
      r_sout        <= w_first_bit;
      r_sout_valid  <= 1'b1;
      r_frame_start <= 1'b1;
    end else if (r_state == ST_SHIFT) begin
      if (r_cnt != '0) begin
        r_shift       <= w_shift_next;
        r_cnt         <= r_cnt - CW'(1);
        r_sout        <= w_next_bit;
        r_frame_start <= 1'b0;
      end else begin
        r_state       <= ST_IDLE;
        r_shift       <= '0;
        r_sout        <= 1'b0;
        r_sout_valid  <= 1'b0;
        r_frame_start <= 1'b0;
      end
    end
  end

  assign sout        = r_sout;
  assign sout_valid  = r_sout_valid;
  assign frame_start = r_frame_start;
  assign busy        = r_sout_valid;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: a 4-bit LSB-first instance with a
// SIPO loopback model, and an 8-bit MSB-first instance.
module tb_piso_serializer;

  logic       clk;
  logic       rst_n;

  logic       load_valid;
  logic       load_ready;
  logic [3:0] load_data;
  logic       sout;
  logic       sout_valid;
  logic       frame_start;
  logic       busy;

  logic       load_valid8;
  logic       load_ready8;
  logic [7:0] load_data8;
  logic       sout8;
  logic       sout_valid8;
  logic       frame_start8;
  logic       busy8;

  logic [3:0] sipo_q;

  int errors = 0;
  int checks = 0;

  piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b1)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .sout(sout), .sout_valid(sout_valid), .frame_start(frame_start), .busy(busy)
  );

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid8), .load_ready(load_ready8), .load_data(load_data8),
    .sout(sout8), .sout_valid(sout_valid8), .frame_start(frame_start8), .busy(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 4-bit SIPO receiver filling from the top so the first bit lands in bit 0
  always @(posedge clk) sipo_q <= {sout, sipo_q[3:1]};

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; load_valid = 1'b0; load_data = '0; load_valid8 = 1'b0; load_data8 = '0;
    #3;
    checks++; if (sout !== 1'b0) begin errors++; $display("FAIL reset_sout got=%b exp=0", sout); end
    checks++; if (sout_valid !== 1'b0) begin errors++; $display("FAIL reset_sout_valid got=%b exp=0", sout_valid); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start got=%b exp=0", frame_start); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready got=%b exp=1", load_ready); end
    checks++; if (load_ready8 !== 1'b1) begin errors++; $display("FAIL reset_load_ready8 got=%b exp=1", load_ready8); end
    step; step;
    rst_n = 1'b1;
    step;
    checks++; if (sout_valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle got=%b exp=0", sout_valid); end
  endtask

  task automatic test_basic;
    logic [3:0] exp_bits;
    exp_bits = 4'b1011;
    load_valid = 1'b1; load_data = 4'b1011;
    step;
    load_valid = 1'b0; load_data = 4'h0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (sout !== exp_bits[k]) begin errors++; $display("FAIL basic_sout bit=%0d got=%b exp=%b", k, sout, exp_bits[k]); end
      checks++; if (sout_valid !== 1'b1) begin errors++; $display("FAIL basic_sout_valid bit=%0d got=%b exp=1", k, sout_valid); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy bit=%0d got=%b exp=1", k, busy); end
      checks++; if (frame_start !== (k == 0)) begin errors++; $display("FAIL basic_frame_start bit=%0d got=%b exp=%b", k, frame_start, (k == 0)); end
      checks++; if (load_ready !== (k == 3)) begin errors++; $display("FAIL basic_load_ready bit=%0d got=%b exp=%b", k, load_ready, (k == 3)); end
      step;
    end
    checks++; if (sout_valid !== 1'b0) begin errors++; $display("FAIL basic_end_valid got=%b exp=0", sout_valid); end
    checks++; if (sout !== 1'b0) begin errors++; $display("FAIL basic_end_sout got=%b exp=0", sout); end
    checks++; if (sipo_q !== 4'hB) begin errors++; $display("FAIL basic_loopback got=%h exp=b", sipo_q); end
    step;
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_bits;
    exp_bits = 8'b0101_1010;  // A (bits 0..3 = 0,1,0,1) then 5 (1,0,1,0)
    load_valid = 1'b1; load_data = 4'hA;
    step;
    load_data = 4'h5;
    for (int k = 0; k < 8; k++) begin
      checks++; if (sout !== exp_bits[k]) begin errors++; $display("FAIL b2b_sout bit=%0d got=%b exp=%b", k, sout, exp_bits[k]); end
      checks++; if (sout_valid !== 1'b1) begin errors++; $display("FAIL b2b_sout_valid bit=%0d got=%b exp=1", k, sout_valid); end
      checks++; if (frame_start !== (k == 0 || k == 4)) begin errors++; $display("FAIL b2b_frame_start bit=%0d got=%b exp=%b", k, frame_start, (k == 0 || k == 4)); end
      if (k == 4) begin
        checks++; if (sipo_q !== 4'hA) begin errors++; $display("FAIL b2b_loopback_a got=%h exp=a", sipo_q); end
        load_valid = 1'b0; load_data = 4'h0;
      end
      step;
    end
    checks++; if (sipo_q !== 4'h5) begin errors++; $display("FAIL b2b_loopback_5 got=%h exp=5", sipo_q); end
    checks++; if (sout_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid got=%b exp=0", sout_valid); end
    step;
  endtask

  task automatic test_backpressure;
    logic [7:0] exp_bits;
    int         ready_low;
    exp_bits  = 8'b1100_0011;  // 3 (1,1,0,0) then C (0,0,1,1)
    ready_low = 0;
    load_valid = 1'b1; load_data = 4'h3;
    step;
    for (int k = 0; k < 8; k++) begin
      if (k == 1) load_data = 4'hC;
      if (k < 4 && load_ready === 1'b0) ready_low++;
      checks++; if (sout !== exp_bits[k]) begin errors++; $display("FAIL bp_sout bit=%0d got=%b exp=%b", k, sout, exp_bits[k]); end
      checks++; if (frame_start !== (k == 0 || k == 4)) begin errors++; $display("FAIL bp_frame_start bit=%0d got=%b exp=%b", k, frame_start, (k == 0 || k == 4)); end
      if (k == 3) begin
        checks++; if (ready_low != 3) begin errors++; $display("FAIL bp_ready_low_cycles got=%0d exp=3", ready_low); end
      end
      if (k == 4) begin
        checks++; if (sipo_q !== 4'h3) begin errors++; $display("FAIL bp_loopback_3 got=%h exp=3", sipo_q); end
        load_valid = 1'b0; load_data = 4'h0;
      end
      step;
    end
    checks++; if (sipo_q !== 4'hC) begin errors++; $display("FAIL bp_loopback_c got=%h exp=c", sipo_q); end
    checks++; if (sout_valid !== 1'b0) begin errors++; $display("FAIL bp_end_valid got=%b exp=0", sout_valid); end
    step;
  endtask

  task automatic test_reset_mid_word;
    load_valid = 1'b1; load_data = 4'hF;
    step;
    load_valid = 1'b0; load_data = 4'h0;
    step;
    checks++; if (sout !== 1'b1) begin errors++; $display("FAIL rmw_bit1 got=%b exp=1", sout); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (sout !== 1'b0) begin errors++; $display("FAIL rmw_async_sout got=%b exp=0", sout); end
    checks++; if (sout_valid !== 1'b0) begin errors++; $display("FAIL rmw_async_valid got=%b exp=0", sout_valid); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL rmw_async_ready got=%b exp=1", load_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmw_async_busy got=%b exp=0", busy); end
    step;
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step;
      checks++; if (sout_valid !== 1'b0 || sout !== 1'b0) begin errors++; $display("FAIL rmw_stays_idle cyc=%0d got=%b%b exp=00", k, sout_valid, sout); end
      checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL rmw_ready_idle cyc=%0d got=%b exp=1", k, load_ready); end
    end
  endtask

  task automatic test_msb_first_w8;
    logic [7:0] exp_seq;
    exp_seq = 8'b1010_0101;  // expected sout order is bit 7 down to bit 0
    load_valid8 = 1'b1; load_data8 = 8'hA5;
    step;
    load_valid8 = 1'b0; load_data8 = 8'h00;
    for (int k = 0; k < 8; k++) begin
      checks++; if (sout8 !== exp_seq[7-k]) begin errors++; $display("FAIL w8_sout bit=%0d got=%b exp=%b", k, sout8, exp_seq[7-k]); end
      checks++; if (sout_valid8 !== 1'b1) begin errors++; $display("FAIL w8_sout_valid bit=%0d got=%b exp=1", k, sout_valid8); end
      checks++; if (frame_start8 !== (k == 0)) begin errors++; $display("FAIL w8_frame_start bit=%0d got=%b exp=%b", k, frame_start8, (k == 0)); end
      checks++; if (load_ready8 !== (k == 7)) begin errors++; $display("FAIL w8_load_ready bit=%0d got=%b exp=%b", k, load_ready8, (k == 7)); end
      step;
    end
    checks++; if (sout_valid8 !== 1'b0) begin errors++; $display("FAIL w8_end_valid got=%b exp=0", sout_valid8); end
    checks++; if (sout8 !== 1'b0) begin errors++; $display("FAIL w8_end_sout got=%b exp=0", sout8); end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL w8_end_busy got=%b exp=0", busy8); end
    step;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_backpressure;
    test_reset_mid_word;
    test_msb_first_w8;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
